// File: rtl/rf_pow_readout.sv
// rf_pow_readout: scans the RF power monitor's 32x16 result RAM one channel
// at a time. For each channel it rebuilds the 24-bit power sum and the
// 18-bit accumulation period. A read is torn when the monitor rewrites the
// MSB word while this block is part-way through the channel. Torn reads are
// retried up to RETRY_MAX times. Each channel then produces one record on a
// valid/ready stream.
//
// Ports:
//   CLK, rst_i       clock; synchronous active-high reset
//   scan_req         one-cycle scan start pulse (queued one-deep while busy)
//   thr_hi, thr_lo   alarm thresholds on the 12-bit average
//   RAD / RFPWR      RAM read address out / registered read data in
//   out_*            record stream (valid/ready) with sum, avg, period, alarms, tear
//   busy, scan_done  scan in progress / pulse after the last record transfers
//   scan_count       completed scans, wrapping 16-bit
module rf_pow_readout #(
    parameter int NUM_CH    = 8,
    parameter int RD_LAT    = 2,   // must be >= 1
    parameter int RETRY_MAX = 3
) (
    input  logic        CLK,
    input  logic        rst_i,
    input  logic        scan_req,
    input  logic [11:0] thr_hi,
    input  logic [11:0] thr_lo,
    output logic [4:0]  RAD,
    input  logic [15:0] RFPWR,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_ch,
    output logic [23:0] out_sum,
    output logic [11:0] out_avg,
    output logic [17:0] out_period,
    output logic        out_hi,
    output logic        out_lo,
    output logic        out_tear,
    output logic        busy,
    output logic        scan_done,
    output logic [15:0] scan_count
);
    localparam int PW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, CHECK, OUT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]  wd_q, wd_d;        // word index within a pass: MSB, LSB, TL, TM, MSB2
    logic [PW-1:0] ph_q, ph_d;      // cycles since RAD moved to the current word
    logic [4:0]  rad_q, rad_d;
    logic [15:0] msb_q, msb_d, tl_q, tl_d, msb2_q, msb2_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [1:0]  tm_q, tm_d;
    logic [23:0] sum_q, sum_d;
    logic [17:0] per_q, per_d;
    logic        hi_q, hi_d, lo_q, lo_d, tear_q, tear_d;
    logic        valid_q, valid_d, done_q, done_d, pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;

    // Fixed RAM map. MSB2 re-reads the MSB address.
    function automatic logic [4:0] addr_of(input logic [2:0] wd, input logic [2:0] ch);
        case (wd)
            3'd1:    addr_of = {2'b00, ch};
            3'd2:    addr_of = 5'd16 + {1'b0, ch, 1'b0};
            3'd3:    addr_of = 5'd17 + {1'b0, ch, 1'b0};
            default: addr_of = 5'd8 + {2'b00, ch};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;  ch_d = ch_q;    retry_d = retry_q;
        wd_d    = wd_q;     ph_d = ph_q;    rad_d   = rad_q;
        msb_d   = msb_q;    lsb_d = lsb_q;  tl_d = tl_q;  tm_d = tm_q;  msb2_d = msb2_q;
        sum_d   = sum_q;    per_d = per_q;  hi_d = hi_q;  lo_d = lo_q;  tear_d = tear_q;
        valid_d = valid_q;  done_d = 1'b0;  cnt_d = cnt_q;  pend_d = pend_q;

        if (scan_req && state_q != IDLE) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                // A request arriving in the scan_done cycle is queued, not
                // started. A request already queued starts straight away and
                // the coincident one is dropped.
                if (pend_q || (scan_req && !done_q)) begin
                    pend_d  = 1'b0;
                    state_d = READ;
                    ch_d    = 3'd0;
                    retry_d = '0;
                    wd_d    = 3'd0;
                    ph_d    = '0;
                    rad_d   = addr_of(3'd0, 3'd0);
                end else if (scan_req) begin
                    pend_d = 1'b1;
                end
            end
            READ: begin
                if (ph_q == PW'(RD_LAT)) begin
                    case (wd_q)
                        3'd0:    msb_d  = RFPWR;
                        3'd1:    lsb_d  = RFPWR[7:0];
                        3'd2:    tl_d   = RFPWR;
                        3'd3:    tm_d   = RFPWR[1:0];
                        default: msb2_d = RFPWR;
                    endcase
                    ph_d = '0;
                    if (wd_q == 3'd4) begin
                        state_d = CHECK;
                    end else begin
                        wd_d  = wd_q + 3'd1;
                        rad_d = addr_of(wd_q + 3'd1, ch_q);
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            CHECK: begin
                if (msb2_q == msb_q || retry_q == RW'(RETRY_MAX)) begin
                    sum_d   = {msb_q, lsb_q};
                    per_d   = {tm_q, tl_q};
                    hi_d    = msb_q[15:4] > thr_hi;
                    lo_d    = msb_q[15:4] < thr_lo;
                    tear_d  = msb2_q != msb_q;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    retry_d = retry_q + RW'(1);
                    wd_d    = 3'd0;
                    ph_d    = '0;
                    rad_d   = addr_of(3'd0, ch_q);
                    state_d = READ;
                end
            end
            default: begin  // OUT
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (ch_q == 3'(NUM_CH - 1)) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        retry_d = '0;
                        wd_d    = 3'd0;
                        ph_d    = '0;
                        rad_d   = addr_of(3'd0, ch_q + 3'd1);
                        state_d = READ;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            state_q <= IDLE;  ch_q <= '0;   retry_q <= '0;  wd_q <= '0;  ph_q <= '0;
            rad_q   <= '0;    msb_q <= '0;  lsb_q <= '0;    tl_q <= '0;  tm_q <= '0;
            msb2_q  <= '0;    sum_q <= '0;  per_q <= '0;    hi_q <= 1'b0; lo_q <= 1'b0;
            tear_q  <= 1'b0;  valid_q <= 1'b0; done_q <= 1'b0; cnt_q <= '0; pend_q <= 1'b0;
        end else begin
            state_q <= state_d;  ch_q <= ch_d;    retry_q <= retry_d;  wd_q <= wd_d;  ph_q <= ph_d;
            rad_q   <= rad_d;    msb_q <= msb_d;  lsb_q <= lsb_d;      tl_q <= tl_d;  tm_q <= tm_d;
            msb2_q  <= msb2_d;   sum_q <= sum_d;  per_q <= per_d;      hi_q <= hi_d;  lo_q <= lo_d;
            tear_q  <= tear_d;   valid_q <= valid_d; done_q <= done_d; cnt_q <= cnt_d; pend_q <= pend_d;
        end
    end

    assign RAD        = rad_q;
    assign out_valid  = valid_q;
    assign out_ch     = ch_q;
    assign out_sum    = sum_q;
    assign out_avg    = sum_q[23:12];
    assign out_period = per_q;
    assign out_hi     = hi_q;
    assign out_lo     = lo_q;
    assign out_tear   = tear_q;
    assign busy       = (state_q != IDLE);
    assign scan_done  = done_q;
    assign scan_count = cnt_q;
endmodule

// File: tb/tb_rf_pow_readout.sv
// Bench for rf_pow_readout. It holds a RAM model with a registered read port
// that can inject tears. Random RAM contents, thresholds and out_ready are
// checked against a record model built from the RAM map rules.
module tb_rf_pow_readout;
    localparam int NUM_CH = 8;

    logic        CLK = 1'b0;
    logic        rst_i, scan_req, out_ready;
    logic [11:0] thr_hi, thr_lo;
    logic [4:0]  RAD;
    logic [15:0] RFPWR;
    logic        out_valid, out_hi, out_lo, out_tear, busy, scan_done;
    logic [2:0]  out_ch;
    logic [23:0] out_sum;
    logic [11:0] out_avg;
    logic [17:0] out_period;
    logic [15:0] scan_count;

    always #5 CLK = ~CLK;

    rf_pow_readout dut (
        .CLK(CLK), .rst_i(rst_i), .scan_req(scan_req), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .RAD(RAD), .RFPWR(RFPWR), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_sum(out_sum), .out_avg(out_avg), .out_period(out_period),
        .out_hi(out_hi), .out_lo(out_lo), .out_tear(out_tear), .busy(busy),
        .scan_done(scan_done), .scan_count(scan_count)
    );

    logic [15:0] ram [0:31];
    int          ent [0:31];   // times RAD moved onto each address
    int          tmode, tbase, cyc, checks, fails;
    logic [4:0]  rad_prev;

    typedef struct {int ch; int sum; int avg; int per; int hi; int lo; int tear; int cyc;} rec_t;
    rec_t recs[$];

    // Monitor RAM with tear injection.
    // Mode 1: ch5 MSB becomes 0x0101 once ch5's TM has been addressed.
    // Mode 2: ch0 MSB bit0 flips every time ch0's TM is addressed.
    function automatic logic [15:0] rd(input logic [4:0] a);
        logic [15:0] v;
        v = ram[a];
        if (tmode == 1 && a == 5'd13 && ent[27] - tbase >= 1) v = 16'h0101;
        if (tmode == 2 && a == 5'd8) v = v ^ 16'((ent[17] - tbase) & 1);
        return v;
    endfunction

    always @(posedge CLK) RFPWR <= rd(RAD);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
        cyc++;
        if (RAD !== rad_prev) ent[RAD]++;
        rad_prev = RAD;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
    endtask

    // Expected record, from the RAM map and the injected tear behaviour.
    task automatic exp_rec(input int ch, output int sum, output int per, output int tear);
        int msb;
        msb  = ram[8 + ch];
        tear = 0;
        if (tmode == 1 && ch == 5) msb = 'h0101;
        // Four passes; the last pass's first MSB read sees three flips.
        if (tmode == 2 && ch == 0) begin msb = ram[8] ^ 1; tear = 1; end
        sum = msb * 256 + (ram[ch] % 256);
        per = (ram[17 + 2 * ch] % 4) * 65536 + ram[16 + 2 * ch];
    endtask

    // rmode: 0 ready always 1, 1 stall 50 cycles at ch2, 2 random ready.
    task automatic run_scan(input int rmode, input bit start, input bit req_mid);
        int stall = 0, budget = 0, unstable = 0;
        bit done = 0, req_next = 0;
        logic [60:0] snap;
        rec_t r;
        recs.delete();
        if (start) begin scan_req = 1'b1; tick(); scan_req = 1'b0; end
        while (!done && budget < 3000) begin
            tick();
            budget++;
            scan_req = req_next;
            req_next = 0;
            if (req_mid && (budget == 30 || budget == 60 || budget == 90)) scan_req = 1'b1;
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) begin
                if (out_valid && out_ch == 3'd2 && stall < 50) begin
                    out_ready = 1'b0;
                    if (stall == 0)
                        snap = {out_valid, out_ch, out_sum, out_avg, out_period, out_hi, out_lo, out_tear};
                    else if ({out_valid, out_ch, out_sum, out_avg, out_period, out_hi, out_lo, out_tear} !== snap)
                        unstable++;
                    stall++;
                end else out_ready = 1'b1;
            end else out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                r.ch = out_ch; r.sum = out_sum; r.avg = out_avg; r.per = out_period;
                r.hi = out_hi; r.lo = out_lo; r.tear = out_tear; r.cyc = cyc;
                recs.push_back(r);
                if (req_mid && out_ch == 3'd7) req_next = 1;
            end
            if (scan_done) done = 1;
        end
        chk("scan_done_seen", done, 1);
        if (rmode == 1) begin
            chk("stall_cycles", stall, 50);
            chk("stall_stable", unstable, 0);
        end
    endtask

    task automatic check_recs(input string t);
        int n, es, ep, et, ea;
        chk({t, "_nrec"}, recs.size(), NUM_CH);
        n = (recs.size() < NUM_CH) ? recs.size() : NUM_CH;
        for (int i = 0; i < n; i++) begin
            exp_rec(i, es, ep, et);
            ea = es / 4096;
            chk($sformatf("%s_ch%0d_id", t, i),   recs[i].ch,   i);
            chk($sformatf("%s_ch%0d_sum", t, i),  recs[i].sum,  es);
            chk($sformatf("%s_ch%0d_avg", t, i),  recs[i].avg,  ea);
            chk($sformatf("%s_ch%0d_per", t, i),  recs[i].per,  ep);
            chk($sformatf("%s_ch%0d_hi", t, i),   recs[i].hi,   (ea > int'(thr_hi)) ? 1 : 0);
            chk($sformatf("%s_ch%0d_lo", t, i),   recs[i].lo,   (ea < int'(thr_lo)) ? 1 : 0);
            chk($sformatf("%s_ch%0d_tear", t, i), recs[i].tear, et);
        end
    endtask

    task automatic chk_reset_state(input string t);
        chk({t, "_valid"}, out_valid, 0);
        chk({t, "_busy"},  busy, 0);
        chk({t, "_rad"},   RAD, 0);
        chk({t, "_cnt"},   scan_count, 0);
        chk({t, "_done"},  scan_done, 0);
        chk({t, "_sum"},   out_sum, 0);
    endtask

    initial begin
        int p, bud;
        checks = 0; fails = 0; cyc = 0; tmode = 0; tbase = 0; rad_prev = '0;
        rst_i = 1'b1; scan_req = 1'b0; out_ready = 1'b1;
        thr_hi = 12'h100; thr_lo = 12'h010;
        fill_ram();
        repeat (3) tick();
        chk_reset_state("rst");
        rst_i = 1'b0;
        tick();

        // Plain scan with fixed ch3 contents.
        fill_ram();
        ram[11] = 16'h1234; ram[3] = 16'h0056; ram[22] = 16'hBEEF; ram[23] = 16'h0003;
        run_scan(0, 1, 0);
        check_recs("t1");
        if (recs.size() == NUM_CH) begin
            chk("t1_ch3_sum", recs[3].sum, 32'h123456);
            chk("t1_ch3_avg", recs[3].avg, 32'h123);
            chk("t1_ch3_per", recs[3].per, 32'h3BEEF);
            chk("t1_ch3_hi",  recs[3].hi, 1);
            chk("t1_ch3_lo",  recs[3].lo, 0);
            chk("t1_ch_gap",  recs[4].cyc - recs[3].cyc, 17);
        end
        chk("t1_cnt",  scan_count, 1);
        chk("t1_busy", busy, 0);

        // Single tear on ch5, random thresholds and ready.
        fill_ram();
        ram[13] = 16'h0100;
        thr_hi = 12'($urandom); thr_lo = 12'($urandom);
        tmode = 1; tbase = ent[27]; p = ent[5];
        run_scan(2, 1, 0);
        check_recs("t2");
        chk("t2_passes", ent[5] - p, 2);

        // Persistent tear on ch0.
        fill_ram();
        thr_hi = 12'($urandom); thr_lo = 12'($urandom);
        tmode = 2; tbase = ent[17]; p = ent[0];
        run_scan(0, 1, 0);
        check_recs("t3");
        chk("t3_passes", ent[0] - p, 4);

        // Backpressure at ch2.
        fill_ram();
        tmode = 0;
        run_scan(1, 1, 0);
        check_recs("t4");

        // Requests during a scan and coincident with scan_done.
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        fill_ram();
        run_scan(0, 1, 1);
        chk("t5_cnt1", scan_count, 1);
        tick();
        scan_req = 1'b0;
        chk("t5_restart", busy, 1);
        run_scan(0, 0, 0);
        check_recs("t5");
        chk("t5_cnt2", scan_count, 2);
        repeat (20) tick();
        chk("t5_idle", busy, 0);
        chk("t5_cnt_final", scan_count, 2);

        // Reset while reading ch4.
        scan_req = 1'b1; tick(); scan_req = 1'b0;
        bud = 0;
        while (RAD !== 5'd4 && bud < 500) begin tick(); bud++; end
        chk("t6_reach_ch4", RAD, 4);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk_reset_state("t6a");
        repeat (3) tick();
        chk("t6a_stay_idle", busy, 0);

        // Reset while holding a record.
        out_ready = 1'b0;
        scan_req = 1'b1; tick(); scan_req = 1'b0;
        bud = 0;
        while (!out_valid && bud < 100) begin tick(); bud++; end
        chk("t6_reach_out", out_valid, 1);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        out_ready = 1'b1;
        chk_reset_state("t6b");
        tick();
        chk("t6b_no_done", scan_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/rf_pow_readout.md
Name: rf_pow_readout

Overview:
- Downstream consumer of the RF power monitor's 32x16 result RAM (read port RAD/RFPWR).
- Scans all 8 mux channels and reassembles each 24-bit power sum and 18-bit accumulation period.
- Detects torn reads, where the monitor rewrites a channel mid-scan, and retries them.
- Emits one record per channel on a valid/ready stream toward the CPCI register/FIFO side, with 12-bit average and threshold alarms.

Parameters:
- NUM_CH, 8: channels scanned, 1..8; channel index is 3 bits.
- RD_LAT, 2: cycles from a RAD update to valid RFPWR capture (this block's RAD register plus the monitor's RFPWR register).
- RETRY_MAX, 3: re-reads allowed per channel on a torn read before the record is flagged.

Ports:
- CLK  in  1  33 MHz system clock; the monitor uses the same clock.
- rst_i  in  1  synchronous, active-high reset.
- scan_req  in  1  one-cycle pulse; starts a scan.
- thr_hi  in  12  high alarm threshold on the average.
- thr_lo  in  12  low alarm threshold on the average.
- RAD  out  5  RAM read address to the monitor.
- RFPWR  in  16  RAM read data from the monitor.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts the record.
- out_ch  out  3  channel of the record.
- out_sum  out  24  {MSB word[15:0], LSB word[7:0]}.
- out_avg  out  12  out_sum[23:12], i.e. sum/4096.
- out_period  out  18  {TM word[1:0], TL word[15:0]}.
- out_hi  out  1  out_avg > thr_hi.
- out_lo  out  1  out_avg < thr_lo.
- out_tear  out  1  record still inconsistent after RETRY_MAX retries.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse after the last record is accepted.
- scan_count  out  16  completed scans, wraps at 2^16.

Behaviour:
- **Reset.** The synchronous rst_i overrides everything, including mid-scan and mid-handshake. Reset values:
  - RAD=0, out_valid=0, all out_* fields=0, busy=0, scan_done=0, scan_count=0.
  - Pending request cleared, state=IDLE.
- **RAM map (fixed, per channel ch):**
  - LSB = ch, bits [7:0] only.
  - MSB = 8+ch.
  - TL = 16+2ch.
  - TM = 17+2ch, bits [1:0] only.
  - Unused upper bits of LSB and TM are ignored.
- **Read timing.** RAD is registered. The word at address A is captured exactly RD_LAT cycles after the cycle RAD becomes A. RAD is held stable for those RD_LAT cycles.
- **States.**
  - IDLE: wait for scan_req or pending. On either, go to READ with ch=0, retry=0, busy=1 in the next cycle, pending cleared.
  - READ: fetch 5 words in order: MSB, LSB, TL, TM, MSB2 (a second read of MSB). This takes 5*(RD_LAT+1) cycles, 15 at default. Then go to CHECK.
  - CHECK (1 cycle):
    - If MSB2==MSB, or retry==RETRY_MAX: form the record, go to OUT. out_tear=1 only when MSB2!=MSB with retry==RETRY_MAX.
    - Otherwise: retry+1, back to READ.
    - A record's fields always come from a single READ pass.
  - OUT: out_valid=1 with all fields stable until the cycle where out_valid&&out_ready.
    - On that transfer: out_valid drops in the next cycle.
    - If ch==NUM_CH-1: pulse scan_done, increment scan_count, go to IDLE (busy=0 the same cycle as scan_done).
    - Else: ch+1, retry=0, go to READ.
- **Alarms.** out_hi and out_lo are computed in CHECK from thr_hi/thr_lo sampled that cycle, unsigned compare. Both may be set if thr_lo>thr_hi.
- **scan_req while busy.** Sets a one-deep pending flag; extra requests while pending are dropped. A pending request starts a new scan on the cycle after return to IDLE.
- **scan_req same cycle as scan_done.** Becomes pending; no request is lost.
- **out_ready=1 continuously.** Gives back-to-back channels with no extra bubble beyond OUT's single cycle.
- **Long out_ready stall.** The block waits indefinitely; RAD holds its last value.
- **Arithmetic.** No arithmetic on the sum; it is pure concatenation. scan_count wraps 0xFFFF -> 0x0000.
- **Cycle count.** Minimum per channel, with no tear and immediate ready: 5*(RD_LAT+1)+2 cycles (17 at default).

Test Plan:
1. **Plain scan.** RAM model with RD_LAT=2: ch3 MSB=0x1234, LSB=0x0056, TL=0xBEEF, TM=0x0003; thr_hi=0x100, thr_lo=0x010; scan_req pulse; out_ready=1.
   Require: 8 records in ch order. ch3 has out_sum=0x123456, out_avg=0x123, out_period=0x3BEEF, out_hi=1, out_lo=0. Then scan_done pulse, scan_count=1.
2. **Single tear.** ch5 MSB changes 0x0100->0x0101 between first and second MSB read on the first pass only.
   Require: exactly one retry; record out_sum={0x0101,LSB}; out_tear=0; RAD sequence shows the READ repeat.
3. **Persistent tear.** ch0 MSB toggles every read.
   Require: 4 READ passes (1+RETRY_MAX); record has out_tear=1; scan continues to ch1.
4. **Backpressure.** out_ready held 0 for 50 cycles at ch2.
   Require: out_valid and all fields stable for those 50 cycles; exactly one transfer when out_ready=1; no duplicated or skipped channel.
5. **Requests during a scan.** Three scan_req pulses mid-scan, plus one coincident with scan_done.
   Require: exactly one further scan starts, the cycle after IDLE; scan_count ends at 2.
6. **Reset mid-scan.** rst_i at ch4 in READ, and again in OUT with out_valid=1.
   Require: the next cycle shows out_valid=0, busy=0, RAD=0, scan_count=0, and no scan_done pulse.
